leds_racer_race_core: RTL

//  N-player race engine: synchronises and debounces player buttons, turns clean

---
 rtl/leds_racer_race_core_if.sv | 22 ++
 rtl/leds_racer_race_core.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/leds_racer_race_core_if.sv
// Race core signal bundle: raw buttons in; press pulses, packed positions/laps, state and winner out.
// The core uses the slave modport; the board-level driver or bench uses master.
interface leds_racer_race_core_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int MAX_POS     = 109,
  parameter int LAPS        = 1
);
  localparam int POS_W = $clog2(MAX_POS);
  localparam int LAP_W = $clog2(LAPS + 1);

  logic [NUM_PLAYERS-1:0]       player_input;
  logic [NUM_PLAYERS-1:0]       press_pulse;
  logic [NUM_PLAYERS*POS_W-1:0] positions;
  logic [NUM_PLAYERS*LAP_W-1:0] laps;
  logic [1:0]                   race_state;
  logic [NUM_PLAYERS-1:0]       winner;

  modport master (output player_input,
                  input  press_pulse, positions, laps, race_state, winner);
  modport slave  (input  player_input,
                  output press_pulse, positions, laps, race_state, winner);
endinterface

// File: rtl/leds_racer_race_core.sv
// N-player race engine: sync + debounce buttons, one-cycle press pulses, per-player position/lap, single winner.
// Raw edge to press_pulse is DEBOUNCE_CLK_CNT+3 cycles, state acts one cycle later; no backpressure, outputs always live.
module leds_racer_race_core #(
  parameter int NUM_PLAYERS      = 4,
  parameter int MAX_POS          = 109,
  parameter int LAPS             = 1,
  parameter int DEBOUNCE_CLK_CNT = 65536,
  parameter int HOLD_CLK_CNT     = 2**26
) (
  input  logic                   clk,
  input  logic                   reset,
  leds_racer_race_core_if.slave  bus
);
  localparam int POS_W  = $clog2(MAX_POS);
  localparam int LAP_W  = $clog2(LAPS + 1);
  localparam int DB_W   = (DEBOUNCE_CLK_CNT > 1) ? $clog2(DEBOUNCE_CLK_CNT) : 1;
  localparam int HOLD_W = (HOLD_CLK_CNT > 1) ? $clog2(HOLD_CLK_CNT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RACING   = 2'd1,
    FINISHED = 2'd2
  } state_t;

  logic [NUM_PLAYERS-1:0] sync1, sync2, deb, deb_d, press_pulse;
  logic [DB_W-1:0]        db_cnt [NUM_PLAYERS];

  // Input path: two-flop synchroniser, then a counter that must see DEBOUNCE_CLK_CNT
  // consecutive disagreeing samples before the clean level follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      deb         <= '0;
      deb_d       <= '0;
      press_pulse <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) db_cnt[i] <= '0;
    end else begin
      sync1       <= bus.player_input;
      sync2       <= sync1;
      deb_d       <= deb;
      press_pulse <= deb & ~deb_d;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CLK_CNT - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  state_t                 state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [NUM_PLAYERS-1:0] winner_q;
  logic [POS_W-1:0]       pos_q [NUM_PLAYERS];
  logic [LAP_W-1:0]       lap_q [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] at_end, fin, first_fin;

  always_comb begin
    at_end = '0;
    fin    = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      at_end[i] = (pos_q[i] == POS_W'(MAX_POS - 1));
      fin[i]    = press_pulse[i] & at_end[i] & ((lap_q[i] + LAP_W'(1)) == LAP_W'(LAPS));
    end
    // Isolate the lowest set bit so a simultaneous finish goes to the lowest index.
    first_fin = fin & (~fin + NUM_PLAYERS'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      winner_q <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos_q[i] <= '0;
        lap_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            pos_q[i] <= '0;
            lap_q[i] <= '0;
          end
          if (|press_pulse) state <= RACING;
        end
        RACING: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (press_pulse[i]) begin
              if (at_end[i]) begin
                pos_q[i] <= '0;
                lap_q[i] <= lap_q[i] + LAP_W'(1);
              end else begin
                pos_q[i] <= pos_q[i] + POS_W'(1);
              end
            end
          end
          if (|fin) begin
            state    <= FINISHED;
            winner_q <= first_fin;
            hold_cnt <= '0;
          end
        end
        FINISHED: begin
          if (hold_cnt == HOLD_W'(HOLD_CLK_CNT - 1)) begin
            state    <= IDLE;
            winner_q <= '0;
            hold_cnt <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              pos_q[i] <= '0;
              lap_q[i] <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          winner_q <= '0;
          hold_cnt <= '0;
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            pos_q[i] <= '0;
            lap_q[i] <= '0;
          end
        end
      endcase
    end
  end

  assign bus.press_pulse = press_pulse;
  assign bus.race_state  = state;
  assign bus.winner      = winner_q;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign bus.positions[g*POS_W +: POS_W] = pos_q[g];
    assign bus.laps[g*LAP_W +: LAP_W]      = lap_q[g];
  end
endmodule
